// File: rtl/vect_dispatch.sv
// vect_dispatch: streams loader words, one vector at a time, into NUM_PIPES pipe FIFOs.
// A free pipe is chosen round-robin for each vector. The whole vector then goes to that
// pipe, stalling while the pipe is full.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  level request to begin a run
//   vect_size, num_vects   run geometry, latched when a run starts
//   in_valid/in_data       loader word (input side)
//   in_ready               word accepted this cycle (combinational)
//   pipe_full              per-pipe FIFO full flags
//   pipe_we/pipe_data      per-pipe write strobe and shared write data (combinational)
//   cur_pipe               pipe owning the current vector
//   vect_count             vectors completed this run
//   busy/done/error        state indicators
module vect_dispatch #(
  parameter int unsigned NUM_PIPES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [15:0]          vect_size,
  input  logic [15:0]          num_vects,
  input  logic                 in_valid,
  input  logic [31:0]          in_data,
  output logic                 in_ready,
  input  logic [NUM_PIPES-1:0] pipe_full,
  output logic [NUM_PIPES-1:0] pipe_we,
  output logic [31:0]          pipe_data,
  output logic [2:0]           cur_pipe,
  output logic [15:0]          vect_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_STREAM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   size_q, nvec_q, word_cnt, vect_cnt;
  logic [IDX_W-1:0]   cur_q, last_q;
  logic [7:0]         full_ext;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [3:0]         cand;
  logic               load_run, sel_take, accept, word_last;

  // Zero-extended full flags so any 3-bit pipe index is a legal select.
  assign full_ext   = 8'(pipe_full);
  assign word_last  = (word_cnt == size_q - 16'd1);
  assign cur_pipe   = cur_q;
  assign vect_count = vect_cnt;

  // Round-robin scan: first non-full pipe starting after the last one chosen.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < int'(NUM_PIPES); i++) begin
      cand = 4'(last_q) + 4'(i) + 4'd1;
      if (cand >= 4'(NUM_PIPES)) cand = cand - 4'(NUM_PIPES);
      if (!sel_found && !full_ext[cand[2:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[2:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state;
    load_run  = 1'b0;
    sel_take  = 1'b0;
    in_ready  = 1'b0;
    accept    = 1'b0;
    pipe_we   = '0;
    pipe_data = '0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;

    if (state == S_STREAM) begin
      in_ready = !full_ext[cur_q];
      accept   = in_ready && in_valid;
    end
    if (accept) begin
      pipe_data = in_data;
      for (int p = 0; p < int'(NUM_PIPES); p++)
        pipe_we[p] = (cur_q == IDX_W'(p));
    end

    unique case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        // A stray loader word outside a run is fatal until reset.
        if (in_valid) begin
          state_d = S_ERROR;
        end else if (start) begin
          load_run = 1'b1;
          state_d  = (vect_size == 16'd0 || num_vects == 16'd0) ? S_DONE : S_SELECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SELECT: begin
        busy = 1'b1;
        if (sel_found) begin
          sel_take = 1'b1;
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        busy = 1'b1;
        if (accept && word_last)
          state_d = (vect_cnt + 16'd1 == nvec_q) ? S_DONE : S_SELECT;
      end
      S_ERROR: begin
        error   = 1'b1;
        state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Run geometry, counters and pipe ownership.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q   <= '0;
      nvec_q   <= '0;
      word_cnt <= '0;
      vect_cnt <= '0;
      cur_q    <= '0;
      last_q   <= IDX_W'(NUM_PIPES - 1);
    end else begin
      if (load_run) begin
        size_q   <= vect_size;
        nvec_q   <= num_vects;
        word_cnt <= '0;
        vect_cnt <= '0;
      end
      if (sel_take) begin
        cur_q  <= sel_idx;
        last_q <= sel_idx;
      end
      if (accept) begin
        if (word_last) begin
          word_cnt <= '0;
          vect_cnt <= vect_cnt + 16'd1;
        end else begin
          word_cnt <= word_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vect_dispatch.sv
// Scoreboard bench for vect_dispatch (NUM_PIPES=2): directed runs push the expected
// pipe writes into a queue, and a negedge monitor checks every write strobe against it.
module tb_vect_dispatch;

  localparam int unsigned NP = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [15:0]   vect_size, num_vects;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic [NP-1:0] pipe_full;
  logic [NP-1:0] pipe_we;
  logic [31:0]   pipe_data;
  logic [2:0]    cur_pipe;
  logic [15:0]   vect_count;
  logic          busy, done, error;

  typedef struct packed {
    logic [2:0]  pipe;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks   = 0;
  int  failures = 0;
  int  cyc_used;

  vect_dispatch #(.NUM_PIPES(NP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .vect_size(vect_size),
    .num_vects(num_vects), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pipe_full(pipe_full), .pipe_we(pipe_we),
    .pipe_data(pipe_data), .cur_pipe(cur_pipe), .vect_count(vect_count),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] p, input logic [31:0] d);
    exp_q.push_back('{pipe: p, data: d});
  endtask

  // Present n consecutive words, advancing on acceptance; bounded by a cycle budget.
  task automatic feed(input int n, input logic [31:0] base, output int cycles);
    int  k;
    logic acc;
    k = 0;
    cycles = 0;
    while (k < n && cycles < 200) begin
      in_valid = 1'b1;
      in_data  = base + 32'(k);
      @(negedge clk);
      acc = in_ready;
      cyc();
      cycles++;
      if (acc) k++;
    end
    in_valid = 1'b0;
    if (k < n) chk("feed_timeout", 32'(k), 32'(n));
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (pipe_we !== '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(pipe_we), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_strobe", 32'(pipe_we), 32'(1) << mon_e.pipe);
        chk("write_data", pipe_data, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; vect_size = '0; num_vects = '0;
    in_valid = 1'b0; in_data = '0; pipe_full = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_pipe_we", 32'(pipe_we), 0);
    chk("rst_pipe_data", pipe_data, 0);
    chk("rst_flags", {29'd0, busy, done, error}, 0);
    chk("rst_vect_count", 32'(vect_count), 0);
    chk("rst_cur_pipe", 32'(cur_pipe), 0);
    reset_n = 1'b1;
    cyc();

    // Basic run: 2 vectors of 3 words, pipe 0 then pipe 1
    push(0, 32'hA0); push(0, 32'hA1); push(0, 32'hA2);
    push(1, 32'hA3); push(1, 32'hA4); push(1, 32'hA5);
    vect_size = 16'd3; num_vects = 16'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("basic_busy", 32'(busy), 1);
    feed(6, 32'hA0, cyc_used);
    chk("basic_cycles", 32'(cyc_used), 8);
    chk("basic_done", 32'(done), 1);
    chk("basic_vect_count", 32'(vect_count), 2);
    chk("basic_busy_off", 32'(busy), 0);
    cyc();
    chk("basic_idle_done", 32'(done), 0);
    chk("basic_count_held", 32'(vect_count), 2);

    // Skip full pipe, then all-full wait in SELECT
    vect_size = 16'd1; num_vects = 16'd2; pipe_full = 2'b01; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("skip_cur_pipe", 32'(cur_pipe), 1);
    push(1, 32'hB0);
    in_valid = 1'b1; in_data = 32'hB0;
    @(negedge clk);
    chk("skip_in_ready", 32'(in_ready), 1);
    cyc();
    in_valid = 1'b0; pipe_full = 2'b11;
    cyc(); cyc();
    @(negedge clk);
    chk("allfull_in_ready", 32'(in_ready), 0);
    chk("allfull_busy", 32'(busy), 1);
    chk("allfull_cur_pipe", 32'(cur_pipe), 1);
    #1 pipe_full = 2'b10;
    cyc();
    chk("freed_cur_pipe", 32'(cur_pipe), 0);
    push(0, 32'hB1);
    in_valid = 1'b1; in_data = 32'hB1;
    cyc();
    in_valid = 1'b0; pipe_full = 2'b00;
    chk("skip_done", 32'(done), 1);
    chk("skip_vect_count", 32'(vect_count), 2);
    cyc();

    // Mid-vector stall; mid-run size change must be ignored
    vect_size = 16'd4; num_vects = 16'd1; start = 1'b1;
    cyc();
    start = 1'b0; vect_size = 16'd2; num_vects = 16'd7;
    cyc();
    chk("stall_cur_pipe", 32'(cur_pipe), 1);
    push(1, 32'hC0); push(1, 32'hC1); push(1, 32'hC2); push(1, 32'hC3);
    in_valid = 1'b1; in_data = 32'hC0;
    cyc();
    in_data = 32'hC1;
    cyc();
    pipe_full = 2'b10; in_data = 32'hC2;
    cyc();
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 0);
    chk("stall_cur_pipe_held", 32'(cur_pipe), 1);
    chk("stall_busy", 32'(busy), 1);
    @(posedge clk); #1;
    pipe_full = 2'b00;
    cyc();
    in_data = 32'hC3;
    cyc();
    in_valid = 1'b0;
    chk("stall_done", 32'(done), 1);
    chk("stall_vect_count", 32'(vect_count), 1);
    cyc();

    // Zero size: straight to DONE, no writes
    vect_size = 16'd0; num_vects = 16'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("zero_done", 32'(done), 1);
    chk("zero_vect_count", 32'(vect_count), 0);
    chk("zero_busy", 32'(busy), 0);
    cyc();
    chk("zero_idle", 32'(done), 0);

    // Async reset mid-STREAM (pipe 0 after last_pipe=1)
    vect_size = 16'd4; num_vects = 16'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("ar_cur_pipe", 32'(cur_pipe), 0);
    push(0, 32'hD0);
    in_valid = 1'b1; in_data = 32'hD0;
    cyc();
    in_data = 32'hD1;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_pipe_we", 32'(pipe_we), 0);
    chk("ar_in_ready", 32'(in_ready), 0);
    chk("ar_pipe_data", pipe_data, 0);
    chk("ar_flags", {29'd0, busy, done, error}, 0);
    chk("ar_vect_count", 32'(vect_count), 0);
    in_valid = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("ar_post_flags", {29'd0, busy, done, error}, 0);

    // First SELECT after reset scans from pipe 0
    vect_size = 16'd1; num_vects = 16'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("post_rst_cur_pipe", 32'(cur_pipe), 0);
    push(0, 32'hE0);
    in_valid = 1'b1; in_data = 32'hE0;
    cyc();
    in_valid = 1'b0;
    chk("post_rst_done", 32'(done), 1);
    cyc();

    // Unexpected word in IDLE -> sticky error
    in_valid = 1'b1; in_data = 32'hF0;
    cyc();
    in_valid = 1'b0;
    chk("err_set", 32'(error), 1);
    chk("err_in_ready", 32'(in_ready), 0);
    start = 1'b1; vect_size = 16'd1; num_vects = 16'd1;
    cyc(); cyc(); cyc();
    start = 1'b0;
    chk("err_sticky", 32'(error), 1);
    chk("err_busy", 32'(busy), 0);
    reset_n = 1'b0;
    #1;
    chk("err_cleared", 32'(error), 0);
    cyc();
    reset_n = 1'b1;
    cyc(); cyc();

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vect_dispatch.md
VECT_DISPATCH -- requirements
Module: vect_dispatch

Interface
REQ-001 SHALL provide parameter NUM_PIPES, default 2: number of pipe FIFOs served; legal range 1..8.
REQ-002 SHALL provide port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL provide port start, input, 1: level request to begin a dispatch run.
REQ-005 SHALL provide port vect_size, input, 16: words per vector; sampled on run start.
REQ-006 SHALL provide port num_vects, input, 16: vectors per run; sampled on run start.
REQ-007 SHALL provide port in_valid, input, 1: loader word available.
REQ-008 SHALL provide port in_data, input, 32: loader word.
REQ-009 SHALL provide port in_ready, output, 1: dispatcher accepts in_data this cycle.
REQ-010 SHALL provide port pipe_full, input, NUM_PIPES: per-pipe FIFO full flags.
REQ-011 SHALL provide port pipe_we, output, NUM_PIPES: per-pipe write strobe, at most one bit high.
REQ-012 SHALL provide port pipe_data, output, 32: write data common to all pipes.
REQ-013 SHALL provide port cur_pipe, output, 3: index of the pipe owning the current vector.
REQ-014 SHALL provide port vect_count, output, 16: vectors fully dispatched this run.
REQ-015 SHALL provide port busy, output, 1: high in SELECT or STREAM.
REQ-016 SHALL provide port done, output, 1: high in DONE.
REQ-017 SHALL provide port error, output, 1: high in ERROR.

Function
REQ-018 SHALL implement states IDLE, SELECT, STREAM, DONE, ERROR.
REQ-019 IDLE: when start=1, SHALL latch vect_size and num_vects; if either is 0 go to DONE, else go to SELECT with word and vector counters cleared.
REQ-020 SELECT: SHALL pick the first pipe with pipe_full=0, scanning round-robin from (last_pipe+1) mod NUM_PIPES; register it into cur_pipe and go to STREAM next cycle.
REQ-021 SELECT with all pipes full: SHALL stay in SELECT, in_ready=0, and rescan every cycle.
REQ-022 The first SELECT after reset SHALL scan from pipe 0; after each SELECT, last_pipe takes the chosen index.
REQ-023 STREAM: in_ready SHALL equal ~pipe_full[cur_pipe], combinationally.
REQ-024 STREAM, in_valid=1 and in_ready=1: pipe_we[cur_pipe]=1 and pipe_data=in_data in the same cycle (zero latency); the word counter increments.
REQ-025 A vector SHALL stay on one pipe; if that pipe becomes full mid-vector, SHALL stall (in_ready=0) and not reselect.
REQ-026 On the accepted word with word counter = vect_size-1: clear the word counter and increment vect_count; if vect_count+1 = num_vects go to DONE, else go to SELECT.
REQ-027 Counters SHALL be 16-bit; all comparisons SHALL use the latched size values; changes on vect_size or num_vects mid-run SHALL have no effect.
REQ-028 DONE: done=1 and vect_count held; start=1 SHALL begin a new run exactly as from IDLE; start=0 SHALL go to IDLE.
REQ-029 in_valid=1 while in IDLE or DONE (unexpected word) SHALL go to ERROR; no write occurs.
REQ-030 ERROR SHALL be sticky until reset_n is low; in_ready=0 and pipe_we=0 in ERROR.
REQ-031 Outside STREAM, in_ready SHALL be 0 and pipe_we SHALL be all-zero.
REQ-032 start deasserting mid-run SHALL not abort the run.

Reset
REQ-033 reset_n low SHALL immediately force state=IDLE, counters=0, last_pipe=NUM_PIPES-1, cur_pipe=0, vect_count=0, latched sizes=0.
REQ-034 During reset: in_ready=0, pipe_we=0, pipe_data=0, busy=0, done=0, error=0.
REQ-035 reset_n asserted mid-STREAM SHALL discard the partial vector; no pipe_we pulse follows the assertion edge.

Verification
REQ-036 Basic run: NUM_PIPES=2, vect_size=3, num_vects=2, no full flags, in_valid held high -> words 0-2 to pipe 0, then words 3-5 to pipe 1 (one idle SELECT cycle between vectors), vect_count=2, done=1.
REQ-037 Skip full pipe: pipe_full=01 at SELECT -> cur_pipe=1; then all full -> stays in SELECT with in_ready=0 until a pipe frees, then selects it.
REQ-038 Mid-vector stall: pipe_full[cur_pipe] rises after word 1 of 4 -> in_ready=0, no writes, no reselect; on clear, words 2-3 go to the same pipe.
REQ-039 Zero size: start with vect_size=0 -> DONE the next cycle, vect_count=0, no pipe_we pulse.
REQ-040 Error: in_valid=1 in IDLE -> error=1 next cycle and held; only reset_n low clears it.
REQ-041 Async reset: reset_n pulsed low between clock edges during STREAM -> all outputs zero before the next edge; state IDLE after reset_n is released.
